// File: rtl/wb_arbiter.sv
// Writeback arbiter: owns the register-file write port, merging ALU results with buffered loads.
// Optional load scoreboard enabled by defining WB_SCOREBOARD_EN.
module wb_arbiter #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    input  logic [4:0]                 alu_rd,
    input  logic [31:0]                alu_data,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [4:0]                 mem_rd,
    input  logic [31:0]                mem_data,
    input  logic                       issue_valid,
    input  logic [4:0]                 issue_rd,
    output logic                       REGS_wen,
    output logic [4:0]                 REGS_wraddr,
    output logic [31:0]                REGS_wrdata,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       stall_req,
    output logic [31:0]                rd_busy
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic [4:0]    fifo_rd_q   [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [LW-1:0] level_q, level_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          stall_q;
    logic          wen_q, wen_d;
    logic [4:0]    waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic alu_ok, fifo_empty, fifo_full, mem_hs, mem_keep;
    logic push, pop, bypass, mem_src;

    assign alu_ok     = alu_valid && (alu_rd != 5'd0);
    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LW'(DEPTH));
    assign mem_ready  = !rst && !fifo_full;
    assign mem_hs     = mem_valid && mem_ready;
    // x0 loads complete the handshake but go nowhere.
    assign mem_keep   = mem_hs && (mem_rd != 5'd0);

    always_comb begin
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        pop     = 1'b0;
        bypass  = 1'b0;
        if (alu_ok) begin
            wen_d   = 1'b1;
            waddr_d = alu_rd;
            wdata_d = alu_data;
        end else if (!fifo_empty) begin
            wen_d   = 1'b1;
            waddr_d = fifo_rd_q[rptr_q];
            wdata_d = fifo_data_q[rptr_q];
            pop     = 1'b1;
        end else if (mem_keep) begin
            wen_d   = 1'b1;
            waddr_d = mem_rd;
            wdata_d = mem_data;
            bypass  = 1'b1;
        end
        push    = mem_keep && !bypass;
        mem_src = pop || bypass;
    end

    always_comb begin
        level_d = level_q + LW'(push) - LW'(pop);
        // Full implies a pop unless the ALU wins, so "not ALU" covers every clear condition.
        if (fifo_full && alu_ok) begin
            starve_d = (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + SW'(1);
        end else begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            level_q  <= level_d;
            starve_q <= starve_d;
            stall_q  <= (starve_d == SW'(STARVE_MAX));
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wptr_q]   <= mem_rd;
            fifo_data_q[wptr_q] <= mem_data;
        end
    end

    assign REGS_wen    = wen_q;
    assign REGS_wraddr = waddr_q;
    assign REGS_wrdata = wdata_q;
    assign fifo_level  = level_q;
    assign stall_req   = stall_q;

`ifdef WB_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (mem_src) busy_d[waddr_d] = 1'b0;
        // Set is applied last so it wins over a same-cycle clear.
        if (issue_valid && (issue_rd != 5'd0)) busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign rd_busy = busy_q;
`else
    logic unused_sb;
    assign unused_sb = ^{issue_valid, issue_rd, mem_src};
    assign rd_busy   = '0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected writes are queued at stimulus time, a monitor
// pops and compares on every REGS_wen. Scoreboard checks run when WB_SCOREBOARD_EN is defined.
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        REGS_wen;
    logic [4:0]  REGS_wraddr;
    logic [31:0] REGS_wrdata;
    logic [2:0]  fifo_level;
    logic        stall_req;
    logic [31:0] rd_busy;

    int tests = 0;
    int fails = 0;
    logic [36:0] exp_q[$];

    wb_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .REGS_wen(REGS_wen), .REGS_wraddr(REGS_wraddr), .REGS_wrdata(REGS_wrdata),
        .fifo_level(fifo_level), .stall_req(stall_req), .rd_busy(rd_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md);
        alu_valid = av; alu_rd = ar; alu_data = ad;
        mem_valid = mv; mem_rd = mr; mem_data = md;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
        exp_q.push_back({rd, data});
    endtask

    // Monitor: every write must match the next queued expectation.
    always @(posedge clk) begin
        #1;
        if (REGS_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {27'd0, REGS_wraddr}, 32'hFFFF_FFFF);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("wr_addr", {27'd0, REGS_wraddr}, {27'd0, e[36:32]});
                check("wr_data", REGS_wrdata, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle();
        tick(); tick();
        check("rst_wen", {31'd0, REGS_wen}, 32'd0);
        check("rst_addr", {27'd0, REGS_wraddr}, 32'd0);
        check("rst_data", REGS_wrdata, 32'd0);
        check("rst_level", {29'd0, fifo_level}, 32'd0);
        check("rst_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_stall", {31'd0, stall_req}, 32'd0);
        check("rst_busy", rd_busy, 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, mem_ready}, 32'd1);

        // 1: single ALU write
        drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        expect_wr(5'd5, 32'h1234);
        tick();
        check("t1_wen", {31'd0, REGS_wen}, 32'd1);
        idle();
        tick();
        check("t1_wen_drop", {31'd0, REGS_wen}, 32'd0);

        // 2: ALU and load collide, load deferred one cycle
        drive(1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB);
        expect_wr(5'd1, 32'hA);
        expect_wr(5'd2, 32'hB);
        tick();
        check("t2_level1", {29'd0, fifo_level}, 32'd1);
        idle();
        tick();
        check("t2_level0", {29'd0, fifo_level}, 32'd0);
        tick();

        // 3: fill FIFO behind ALU, then drain in push order
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'(20 + i), 32'(32'h200 + i), 1'b1, 5'(1 + i), 32'(32'h100 + i));
            expect_wr(5'(20 + i), 32'(32'h200 + i));
            tick();
        end
        idle();
        #1;
        check("t3_full_level", {29'd0, fifo_level}, 32'd4);
        check("t3_full_ready", {31'd0, mem_ready}, 32'd0);
        for (int i = 0; i < 4; i++) expect_wr(5'(1 + i), 32'(32'h100 + i));
        tick();
        check("t3_ready_after_pop", {31'd0, mem_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_drain_wen", {31'd0, REGS_wen}, 32'd1);
        end
        tick();
        check("t3_empty", {29'd0, fifo_level}, 32'd0);

        // 4: starvation of a full FIFO
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'(24 + i), 32'(32'h300 + i), 1'b1, 5'(5 + i), 32'(32'h400 + i));
            expect_wr(5'(24 + i), 32'(32'h300 + i));
            tick();
        end
        for (int j = 1; j <= 8; j++) begin
            drive(1'b1, 5'd9, 32'(j), 1'b0, 5'd0, 32'd0);
            expect_wr(5'd9, 32'(j));
            tick();
            if (j == 7) check("t4_stall_at7", {31'd0, stall_req}, 32'd0);
        end
        check("t4_stall_at8", {31'd0, stall_req}, 32'd1);
        drive(1'b1, 5'd9, 32'hDEAD, 1'b0, 5'd0, 32'd0);
        expect_wr(5'd9, 32'hDEAD);
        tick();
        check("t4_stall_sat", {31'd0, stall_req}, 32'd1);
        idle();
        for (int i = 0; i < 4; i++) expect_wr(5'(5 + i), 32'(32'h400 + i));
        tick();
        check("t4_stall_clear", {31'd0, stall_req}, 32'd0);
        check("t4_level3", {29'd0, fifo_level}, 32'd3);
        tick(); tick(); tick();

        // 5: x0 filtering
        drive(1'b1, 5'd3, 32'h31, 1'b1, 5'd17, 32'h117);
        expect_wr(5'd3, 32'h31);
        tick();
        drive(1'b1, 5'd3, 32'h32, 1'b1, 5'd18, 32'h118);
        expect_wr(5'd3, 32'h32);
        tick();
        check("t5_level2", {29'd0, fifo_level}, 32'd2);
        drive(1'b1, 5'd0, 32'hBAD, 1'b0, 5'd0, 32'd0);
        expect_wr(5'd17, 32'h117);
        tick();
        check("t5_x0_pop", {29'd0, fifo_level}, 32'd1);
        drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd0, 32'hBAD);
        expect_wr(5'd6, 32'h66);
        tick();
        check("t5_memx0_level", {29'd0, fifo_level}, 32'd1);
        idle();
        expect_wr(5'd18, 32'h118);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBAD);
        #1;
        check("t5_memx0_ready", {31'd0, mem_ready}, 32'd1);
        tick();
        check("t5_memx0_nowen", {31'd0, REGS_wen}, 32'd0);
        check("t5_memx0_empty", {29'd0, fifo_level}, 32'd0);
        idle();
        tick();

`ifdef WB_SCOREBOARD_EN
        // 6: scoreboard set/clear
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        check("t6_busy_set", rd_busy, 32'h0000_0080);
        idle();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h55);
        expect_wr(5'd7, 32'h55);
        tick();
        check("t6_clear_wen", {31'd0, REGS_wen}, 32'd1);
        check("t6_busy_clear", rd_busy, 32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h88);
        issue_valid = 1'b1; issue_rd = 5'd8;
        expect_wr(5'd8, 32'h88);
        tick();
        check("t6_set_wins", rd_busy, 32'h0000_0100);
        idle();
        issue_valid = 1'b1; issue_rd = 5'd12;
        tick();
        issue_valid = 1'b0;
`else
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        check("nosb_busy_zero", rd_busy, 32'd0);
        idle();
`endif

        // Reset mid-operation with three queued loads
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(10 + i), 32'(32'h500 + i), 1'b1, 5'(13 + i), 32'(32'h600 + i));
            expect_wr(5'(10 + i), 32'(32'h500 + i));
            tick();
        end
        check("rst3_level_pre", {29'd0, fifo_level}, 32'd3);
        idle();
        rst = 1'b1;
        tick();
        check("rst3_level", {29'd0, fifo_level}, 32'd0);
        check("rst3_wen", {31'd0, REGS_wen}, 32'd0);
        check("rst3_busy", rd_busy, 32'd0);
        rst = 1'b0;
        tick(); tick();
        check("rst3_no_wen", {31'd0, REGS_wen}, 32'd0);
        check("exp_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
